// File: rtl/arp_ctrl.sv
// arp_ctrl: sequences the ARP transmitter. Answers ARP requests addressed to
// us and resolves IP addresses to MACs with broadcast requests, per-attempt
// timeout and bounded retries. Sole owner of the tx start strobe.
// Optional feature: define ARP_CACHE_EN for a single-entry {ip, mac} cache
// that lets a resolve complete without sending a request.
module arp_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 125_000_000,
    parameter int unsigned RETRY_MAX   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] source_mac,
    input  logic [31:0] source_ip,
    input  logic        resolve_req,
    input  logic [31:0] resolve_ip,
    output logic        resolve_ready,
    output logic        resolve_done,
    output logic        resolve_ok,
    output logic [47:0] resolve_mac,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    input  logic        arp_tx_done
);

    localparam int unsigned   TW         = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned   RW         = $clog2(RETRY_MAX + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);

    typedef enum logic [1:0] {
        IDLE,
        TX_REPLY,
        TX_REQ,
        WAIT_ACK
    } state_t;

    state_t        state_q, state_d;
    logic          ret_wait_q, ret_wait_d;
    logic          reply_pend_q, reply_pend_d;
    logic [47:0]   rep_mac_q, rep_mac_d;
    logic [31:0]   rep_ip_q, rep_ip_d;
    logic [31:0]   tgt_ip_q, tgt_ip_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          ready_q, ready_d;
    logic          tx_en_q, tx_en_d;
    logic          tx_type_q, tx_type_d;
    logic [47:0]   des_mac_q, des_mac_d;
    logic [31:0]   des_ip_q, des_ip_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;
    logic [47:0]   mac_q, mac_d;

    logic          accept;
    logic          match;
    logic          timeout;
    logic          serve_reply;
    logic          issue_req;
    logic          cache_hit;
    logic [47:0]   cache_mac;

    assign accept  = resolve_req && ready_q;
    assign match   = arp_rx_done && arp_rx_type && (source_ip == tgt_ip_q);
    assign timeout = (timer_q == TIMER_LAST);

`ifdef ARP_CACHE_EN
    logic        cache_vld_q;
    logic [31:0] cache_ip_q;
    logic [47:0] cache_mac_q;

    // Remember the sender of the most recent ARP packet of either type
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
            cache_ip_q  <= '0;
            cache_mac_q <= '0;
        end else if (arp_rx_done) begin
            cache_vld_q <= 1'b1;
            cache_ip_q  <= source_ip;
            cache_mac_q <= source_mac;
        end
    end

    assign cache_hit = cache_vld_q && (cache_ip_q == resolve_ip);
    assign cache_mac = cache_mac_q;
`else
    assign cache_hit = 1'b0;
    assign cache_mac = '0;
`endif

    // Next-state, pending-reply capture and registered output values
    always_comb begin
        state_d      = state_q;
        ret_wait_d   = ret_wait_q;
        reply_pend_d = reply_pend_q;
        rep_mac_d    = rep_mac_q;
        rep_ip_d     = rep_ip_q;
        tgt_ip_d     = tgt_ip_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        tx_en_d      = 1'b0;
        tx_type_d    = tx_type_q;
        des_mac_d    = des_mac_q;
        des_ip_d     = des_ip_q;
        done_d       = 1'b0;
        ok_d         = ok_q;
        mac_d        = mac_q;
        serve_reply  = 1'b0;
        issue_req    = 1'b0;

        // The timer keeps running through a reply detour and saturates, so a
        // timeout that expires during the detour is acted on after returning.
        if ((state_q == WAIT_ACK || (state_q == TX_REPLY && ret_wait_q)) && !timeout) begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_ip_d = resolve_ip;
                    retry_d  = '0;
                    if (cache_hit) begin
                        done_d = 1'b1;
                        ok_d   = 1'b1;
                        mac_d  = cache_mac;
                    end else begin
                        issue_req = 1'b1;
                    end
                end else if (reply_pend_q) begin
                    ret_wait_d  = 1'b0;
                    serve_reply = 1'b1;
                end
            end
            TX_REPLY: begin
                if (arp_tx_done) begin
                    state_d = ret_wait_q ? WAIT_ACK : IDLE;
                end
            end
            TX_REQ: begin
                if (arp_tx_done) begin
                    state_d = WAIT_ACK;
                    timer_d = '0;
                    retry_d = retry_q + RW'(1);
                end
            end
            WAIT_ACK: begin
                if (match) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                    mac_d   = source_mac;
                    state_d = IDLE;
                end else if (reply_pend_q) begin
                    ret_wait_d  = 1'b1;
                    serve_reply = 1'b1;
                end else if (timeout) begin
                    if (retry_q < RETRY_LIM) begin
                        issue_req = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        ok_d    = 1'b0;
                        mac_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_req) begin
            state_d   = TX_REQ;
            tx_en_d   = 1'b1;
            tx_type_d = 1'b0;
            des_mac_d = '1;
            des_ip_d  = tgt_ip_d;
        end

        if (serve_reply) begin
            state_d      = TX_REPLY;
            tx_en_d      = 1'b1;
            tx_type_d    = 1'b1;
            des_mac_d    = rep_mac_q;
            des_ip_d     = rep_ip_q;
            reply_pend_d = 1'b0;
        end

        // Capture last so a request arriving while another is served stays pending
        if (arp_rx_done && !arp_rx_type) begin
            reply_pend_d = 1'b1;
            rep_mac_d    = source_mac;
            rep_ip_d     = source_ip;
        end

        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ret_wait_q   <= 1'b0;
            reply_pend_q <= 1'b0;
            rep_mac_q    <= '0;
            rep_ip_q     <= '0;
            tgt_ip_q     <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            ready_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_type_q    <= 1'b0;
            des_mac_q    <= '0;
            des_ip_q     <= '0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            mac_q        <= '0;
        end else begin
            state_q      <= state_d;
            ret_wait_q   <= ret_wait_d;
            reply_pend_q <= reply_pend_d;
            rep_mac_q    <= rep_mac_d;
            rep_ip_q     <= rep_ip_d;
            tgt_ip_q     <= tgt_ip_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            ready_q      <= ready_d;
            tx_en_q      <= tx_en_d;
            tx_type_q    <= tx_type_d;
            des_mac_q    <= des_mac_d;
            des_ip_q     <= des_ip_d;
            done_q       <= done_d;
            ok_q         <= ok_d;
            mac_q        <= mac_d;
        end
    end

    assign resolve_ready = ready_q;
    assign resolve_done  = done_q;
    assign resolve_ok    = ok_q;
    assign resolve_mac   = mac_q;
    assign arp_tx_en     = tx_en_q;
    assign arp_tx_type   = tx_type_q;
    assign des_mac       = des_mac_q;
    assign des_ip        = des_ip_q;

endmodule
